// File: rtl/led_shift_tx_pkg.sv
// Shared constants, FSM state type and status-word layout for the LED shift transmitter.
// Imported by both the bus-facing top and the serialiser core.
package led_shift_tx_pkg;

    localparam logic [15:0] ADDR_DATA = 16'hC010;
    localparam logic [15:0] ADDR_STAT = 16'hC011;

    localparam int STAT_BUSY = 0;
    localparam int STAT_PEND = 1;
    localparam int STAT_OVR  = 2;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } state_e;

    function automatic logic [15:0] make_status(input logic busy, input logic pend, input logic ovr);
        logic [15:0] s;
        s            = '0;
        s[STAT_BUSY] = busy;
        s[STAT_PEND] = pend;
        s[STAT_OVR]  = ovr;
        return s;
    endfunction

endpackage

// File: rtl/led_shift_tx_if.sv
// CPU-side I/O bus shared with exmem: address/data/strobes in, registered status readback out.
// No backpressure: writes are always accepted, reads answer one cycle after the strobe.
interface led_shift_tx_if;
    logic        memwrite;
    logic        memread;
    logic [15:0] adr;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        rd_valid;

    modport master (
        output memwrite, memread, adr, writedata,
        input  readdata, rd_valid
    );

    modport slave (
        input  memwrite, memread, adr, writedata,
        output readdata, rd_valid
    );
endinterface

// File: rtl/led_shift_core.sv
// Serialiser for a 74HC595 chain: shifts a word MSB-first, then pulses latch; 2*WIDTH*CLK_DIV+CLK_DIV cycles busy.
// Loads start_dat_i only from IDLE or on the final LATCH cycle (take_o); start_i is ignored otherwise.
module led_shift_core
    import led_shift_tx_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] start_dat_i,
    output logic             take_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             sr_data_o,
    output logic             sr_clk_o,
    output logic             sr_latch_o
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(WIDTH);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             div_last;
    logic             load;

    assign div_last = (div_q == DIV_LAST);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: load = start_i;
            SHIFT_LO: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = SHIFT_HI;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            SHIFT_HI: begin
                if (div_last) begin
                    div_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = LATCH;
                    end else begin
                        // Data only moves while sr_clk is low so the chain sees stable setup.
                        sh_d    = {sh_q[WIDTH-2:0], 1'b0};
                        bit_d   = bit_q + 1'b1;
                        state_d = SHIFT_LO;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            LATCH: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = IDLE;
                    load    = start_i;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            sh_d    = start_dat_i;
            bit_d   = '0;
            div_d   = '0;
            state_d = SHIFT_LO;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
        end
    end

    assign take_o     = load;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == LATCH) && div_last;
    assign sr_clk_o   = (state_q == SHIFT_HI);
    assign sr_latch_o = (state_q == LATCH);
    assign sr_data_o  = ((state_q == SHIFT_LO) || (state_q == SHIFT_HI)) && sh_q[WIDTH-1];

endmodule

// File: rtl/led_shift_tx.sv
// Memory-mapped LED chain transmitter: address decode, one-deep pending buffer, sticky overrun, status readback.
// Status reads answer next cycle; a data write while busy with a full pending slot is dropped and flags overrun.
module led_shift_tx
    import led_shift_tx_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int CLK_DIV = 4
) (
    input  logic           clk,
    input  logic           rst,
    led_shift_tx_if.slave  bus,
    output logic           sr_data,
    output logic           sr_clk,
    output logic           sr_latch,
    output logic           busy,
    output logic           done
);

    logic             hit_data, hit_stat_wr, hit_stat_rd;
    logic             direct, to_pend, consume, pend_free, ovr_set;
    logic             core_start, core_take;
    logic [WIDTH-1:0] core_dat;

    logic             pend_valid_q, pend_valid_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             ovr_q, ovr_d;
    logic [15:0]      readdata_q, readdata_d;
    logic             rd_valid_q, rd_valid_d;

    assign hit_data    = bus.memwrite && (bus.adr == ADDR_DATA);
    assign hit_stat_wr = bus.memwrite && (bus.adr == ADDR_STAT);
    assign hit_stat_rd = bus.memread  && (bus.adr == ADDR_STAT);

    always_comb begin
        // A pending word always goes first; a fresh write only bypasses the buffer when fully idle.
        direct       = hit_data && !busy && !pend_valid_q;
        core_start   = pend_valid_q || direct;
        core_dat     = pend_valid_q ? pend_q : bus.writedata[WIDTH-1:0];
        consume      = core_take && pend_valid_q;
        pend_free    = !pend_valid_q || consume;
        to_pend      = hit_data && !direct;

        pend_valid_d = pend_valid_q;
        pend_d       = pend_q;
        ovr_set      = 1'b0;
        if (consume) begin
            pend_valid_d = 1'b0;
        end
        if (to_pend) begin
            if (pend_free) begin
                pend_d       = bus.writedata[WIDTH-1:0];
                pend_valid_d = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end
        ovr_d      = ovr_set || (ovr_q && !(hit_stat_wr && bus.writedata[STAT_OVR]));

        rd_valid_d = hit_stat_rd;
        readdata_d = hit_stat_rd ? make_status(busy, pend_valid_q, ovr_q) : 16'h0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
            ovr_q        <= 1'b0;
            readdata_q   <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_q       <= pend_d;
            ovr_q        <= ovr_d;
            readdata_q   <= readdata_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.rd_valid = rd_valid_q;

    led_shift_core #(
        .WIDTH   (WIDTH),
        .CLK_DIV (CLK_DIV)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .start_i     (core_start),
        .start_dat_i (core_dat),
        .take_o      (core_take),
        .busy_o      (busy),
        .done_o      (done),
        .sr_data_o   (sr_data),
        .sr_clk_o    (sr_clk),
        .sr_latch_o  (sr_latch)
    );

endmodule

// File: tb/tb_led_shift_tx.sv
// Bench for led_shift_tx: directed scenarios plus a randomized write/read stream scored against a transaction model.
module tb_led_shift_tx;

    localparam int W = 16;
    localparam int D = 4;
    localparam int T = 2 * W * D + D;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    led_shift_tx_if bus ();
    led_shift_tx_if bus2 ();

    logic sr_data, sr_clk, sr_latch, busy, done;
    logic b_sr_data, b_sr_clk, b_sr_latch, b_busy, b_done;

    led_shift_tx #(.WIDTH(W), .CLK_DIV(D)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .sr_data(sr_data), .sr_clk(sr_clk), .sr_latch(sr_latch), .busy(busy), .done(done)
    );

    led_shift_tx #(.WIDTH(2), .CLK_DIV(1)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2),
        .sr_data(b_sr_data), .sr_clk(b_sr_clk), .sr_latch(b_sr_latch), .busy(b_busy), .done(b_done)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Transaction model: each accepted word occupies the transmitter for exactly T cycles.
    int          m_rem = 0;
    logic        m_pend_v = 1'b0;
    logic [15:0] m_pend = '0;
    logic        m_ovr = 1'b0;
    logic [15:0] m_stat = '0;
    int          m_done = 0;
    logic [15:0] exp_q[$];

    always @(posedge clk) begin : model
        logic hit, clr, bsy, ext, oset;
        if (rst) begin
            m_rem = 0; m_pend_v = 1'b0; m_ovr = 1'b0; m_stat = '0;
        end else begin
            hit  = bus.memwrite && (bus.adr == 16'hC010);
            clr  = bus.memwrite && (bus.adr == 16'hC011) && bus.writedata[2];
            bsy  = (m_rem > 0);
            ext  = (m_rem == 1);
            oset = 1'b0;
            m_stat = {13'b0, m_ovr, m_pend_v, bsy};
            if (ext) m_done++;
            if (!bsy || (ext && m_pend_v)) begin
                if (m_pend_v) begin
                    m_rem = T; exp_q.push_back(m_pend); m_pend_v = 1'b0;
                    if (hit) begin m_pend = bus.writedata; m_pend_v = 1'b1; end
                end else if (hit) begin
                    m_rem = T; exp_q.push_back(bus.writedata);
                end
            end else begin
                m_rem--;
                if (hit) begin
                    if (!m_pend_v) begin m_pend = bus.writedata; m_pend_v = 1'b1; end
                    else oset = 1'b1;
                end
            end
            m_ovr = oset || (m_ovr && !clr);
        end
    end

    // Chain-side monitor: what a 74HC595 would capture on sr_clk rises, committed on each latch.
    logic        bits[$];
    logic [15:0] got_q[$];
    int          got_done = 0;
    logic        prev_clk = 1'b0, prev_lat = 1'b0;

    always @(negedge clk) begin : monitor
        logic [15:0] w;
        if (rst) begin
            bits.delete();
        end else begin
            if (sr_clk && !prev_clk) bits.push_back(sr_data);
            if (sr_latch && !prev_lat) begin
                w = '0;
                foreach (bits[i]) w = {w[14:0], bits[i]};
                got_q.push_back(w);
                bits.delete();
            end
            if (done) got_done++;
        end
        prev_clk = sr_clk;
        prev_lat = sr_latch;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.memwrite = 1'b0; bus.memread = 1'b0; bus.adr = '0; bus.writedata = '0;
        bus2.memwrite = 1'b0; bus2.memread = 1'b0; bus2.adr = '0; bus2.writedata = '0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        bus.memwrite = 1'b1; bus.adr = a; bus.writedata = d;
        tick();
        bus.memwrite = 1'b0; bus.adr = '0; bus.writedata = '0;
    endtask

    task automatic rd(input logic [15:0] a);
        bus.memread = 1'b1; bus.adr = a;
        tick();
        bus.memread = 1'b0; bus.adr = '0;
    endtask

    task automatic clear_sb();
        exp_q.delete(); got_q.delete(); m_done = 0; got_done = 0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (busy === 1'b0 && m_rem == 0 && !m_pend_v) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.memwrite = 1'b1; bus.memread = 1'b1; bus.adr = 16'hC011; bus.writedata = 16'hFFFF;
        repeat (3) tick();
        n_chk++; if (bus.readdata !== 16'h0000) begin n_fail++; $display("FAIL reset_readdata: got %h expected 0000", bus.readdata); end
        n_chk++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 0", bus.rd_valid); end
        n_chk++; if ({sr_data, sr_clk, sr_latch} !== 3'b000) begin n_fail++; $display("FAIL reset_serial: got %b expected 000", {sr_data, sr_clk, sr_latch}); end
        n_chk++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_done: got %b expected 00", {busy, done}); end
        n_chk++; if ({b_busy, b_sr_clk, b_sr_latch} !== 3'b000) begin n_fail++; $display("FAIL reset_dut2: got %b expected 000", {b_busy, b_sr_clk, b_sr_latch}); end
        rst = 1'b0;
        bus_idle();
        tick();
    endtask

    task automatic test_single();
        int busy_n, lat_n, done_n, done_at;
        clear_sb();
        wr(16'hC010, 16'hA5C3);
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_rise: got %b expected 1", busy); end
        n_chk++; if ({sr_data, sr_clk} !== 2'b10) begin n_fail++; $display("FAIL single_first_bit: got %b expected 10", {sr_data, sr_clk}); end
        busy_n = 0; lat_n = 0; done_n = 0; done_at = 0;
        for (int i = 1; i <= 400 && busy === 1'b1; i++) begin
            busy_n++;
            if (sr_latch) lat_n++;
            if (done) begin done_n++; done_at = i; end
            tick();
        end
        n_chk++; if (busy_n != T) begin n_fail++; $display("FAIL single_busy_len: got %0d expected %0d", busy_n, T); end
        n_chk++; if (done_at != T || done_n != 1) begin n_fail++; $display("FAIL single_done: got at %0d x%0d expected at %0d x1", done_at, done_n, T); end
        n_chk++; if (lat_n != D) begin n_fail++; $display("FAIL single_latch_len: got %0d expected %0d", lat_n, D); end
        n_chk++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL single_after: got %b expected 00", {busy, done}); end
        n_chk++; if (got_q.size() != 1 || got_q[0] !== 16'hA5C3) begin n_fail++; $display("FAIL single_pattern: got %0d words first %h expected 1 word A5C3", got_q.size(), got_q[0]); end
    endtask

    task automatic test_back_to_back();
        int gap, done_n;
        clear_sb();
        wr(16'hC010, 16'h0001);
        repeat (8) tick();
        wr(16'hC010, 16'h8000);
        rd(16'hC011);
        n_chk++; if (bus.readdata !== 16'h0003 || bus.readdata !== m_stat || bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_status: got %h/%b expected 0003/1", bus.readdata, bus.rd_valid); end
        gap = 0; done_n = 0;
        for (int i = 0; i < 1000 && done_n < 2; i++) begin
            if (busy !== 1'b1) gap++;
            if (done) done_n++;
            tick();
        end
        n_chk++; if (gap != 0 || done_n != 2) begin n_fail++; $display("FAIL b2b_no_gap: got gap %0d done %0d expected gap 0 done 2", gap, done_n); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end_idle: got %b expected 0", busy); end
        n_chk++; if (got_q.size() != 2 || got_q[0] !== 16'h0001 || got_q[1] !== 16'h8000) begin n_fail++; $display("FAIL b2b_patterns: got %0d words %h %h expected 0001 8000", got_q.size(), got_q[0], got_q[1]); end
    endtask

    task automatic test_overrun();
        bit ok;
        clear_sb();
        wr(16'hC010, 16'h1111);
        repeat (3) tick();
        wr(16'hC010, 16'h2222);
        repeat (3) tick();
        wr(16'hC010, 16'h3333);
        rd(16'hC011);
        n_chk++; if (bus.readdata !== 16'h0007) begin n_fail++; $display("FAIL ovr_status_full: got %h expected 0007", bus.readdata); end
        for (int i = 0; i < 400 && done !== 1'b1; i++) tick();
        tick();
        repeat (5) tick();
        rd(16'hC011);
        n_chk++; if (bus.readdata !== 16'h0005 || bus.readdata !== m_stat) begin n_fail++; $display("FAIL ovr_status_second: got %h expected 0005", bus.readdata); end
        wr(16'hC011, 16'h0004);
        rd(16'hC011);
        n_chk++; if (bus.readdata !== 16'h0001) begin n_fail++; $display("FAIL ovr_cleared: got %h expected 0001", bus.readdata); end
        wait_idle(ok);
        rd(16'hC011);
        n_chk++; if (!ok || bus.readdata !== 16'h0000) begin n_fail++; $display("FAIL ovr_final_status: got %h idle %0d expected 0000 idle 1", bus.readdata, ok); end
        n_chk++; if (got_q.size() != 2 || got_q[0] !== 16'h1111 || got_q[1] !== 16'h2222) begin n_fail++; $display("FAIL ovr_words: got %0d words %h %h expected 1111 2222", got_q.size(), got_q[0], got_q[1]); end
    endtask

    task automatic test_reset_mid();
        int rises;
        logic prev;
        bit ok;
        clear_sb();
        wr(16'hC010, 16'h5A3C);
        rises = 0; prev = sr_clk;
        for (int i = 0; i < 400 && rises < 8; i++) begin
            tick();
            if (sr_clk && !prev) rises++;
            prev = sr_clk;
        end
        n_chk++; if (rises != 8) begin n_fail++; $display("FAIL mid_reach_bit7: got %0d rises expected 8", rises); end
        rst = 1'b1; bus.memread = 1'b1; bus.adr = 16'hC011;
        tick();
        n_chk++; if ({sr_clk, sr_latch, busy, done, bus.rd_valid} !== 5'b0 || bus.readdata !== 16'h0000) begin n_fail++; $display("FAIL mid_reset_outputs: got clk/lat/busy/done/vld %b rd %h expected 00000 0000", {sr_clk, sr_latch, busy, done, bus.rd_valid}, bus.readdata); end
        rst = 1'b0;
        bus_idle();
        tick();
        clear_sb();
        wr(16'hC010, 16'hFFFF);
        wait_idle(ok);
        n_chk++; if (!ok || got_q.size() != 1 || got_q[0] !== 16'hFFFF) begin n_fail++; $display("FAIL mid_recover: got %0d words %h expected 1 word FFFF", got_q.size(), got_q[0]); end
    endtask

    task automatic test_addr_filter();
        clear_sb();
        wr(16'hC012, 16'h1234);
        wr(16'h002A, 16'hFFFF);
        rd(16'hC010);
        n_chk++; if (busy !== 1'b0 || bus.rd_valid !== 1'b0 || bus.readdata !== 16'h0000) begin n_fail++; $display("FAIL filter_ignored: got busy %b vld %b rd %h expected 0 0 0000", busy, bus.rd_valid, bus.readdata); end
        rd(16'hC011);
        n_chk++; if (bus.rd_valid !== 1'b1 || bus.readdata !== 16'h0000) begin n_fail++; $display("FAIL filter_stat_read: got vld %b rd %h expected 1 0000", bus.rd_valid, bus.readdata); end
        tick();
        n_chk++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL filter_vld_drop: got %b expected 0", bus.rd_valid); end
        repeat (20) tick();
        n_chk++; if (got_q.size() != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL filter_no_tx: got %0d words busy %b expected 0 0", got_q.size(), busy); end
    endtask

    task automatic test_random();
        bit ok, rd_stat;
        int r, bad_busy, bad_rd;
        clear_sb();
        bad_busy = 0; bad_rd = 0;
        for (int c = 0; c < 3000; c++) begin
            bus_idle();
            r = $urandom_range(0, 99);
            if (r < 3) begin
                bus.memwrite = 1'b1; bus.adr = 16'hC010; bus.writedata = 16'($urandom);
            end else if (r < 5) begin
                bus.memwrite = 1'b1; bus.adr = 16'hC011; bus.writedata = 16'($urandom);
            end
            if ($urandom_range(0, 7) == 0) begin
                bus.memread = 1'b1;
                if (!bus.memwrite) bus.adr = ($urandom_range(0, 3) != 0) ? 16'hC011 : 16'hC010;
            end
            rd_stat = bus.memread && (bus.adr == 16'hC011);
            tick();
            n_chk++; if (busy !== (m_rem > 0)) begin n_fail++; bad_busy++; if (bad_busy < 5) $display("FAIL rand_busy: cycle %0d got %b expected %b", c, busy, m_rem > 0); end
            n_chk++; if (bus.rd_valid !== rd_stat || bus.readdata !== (rd_stat ? m_stat : 16'h0000)) begin n_fail++; bad_rd++; if (bad_rd < 5) $display("FAIL rand_read: cycle %0d got %b/%h expected %b/%h", c, bus.rd_valid, bus.readdata, rd_stat, rd_stat ? m_stat : 16'h0000); end
        end
        bus_idle();
        wait_idle(ok);
        tick();
        n_chk++; if (!ok || got_q.size() != exp_q.size() || got_done != m_done) begin n_fail++; $display("FAIL rand_counts: got %0d words %0d done expected %0d words %0d done", got_q.size(), got_done, exp_q.size(), m_done); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_word: index %0d got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_boundary();
        logic [15:0] words[2];
        logic [1:0]  pat;
        logic        prev;
        int          busy_n, done_at, lat_n, nb;
        words[0] = 16'h0002;
        words[1] = 16'hFFF1;
        foreach (words[k]) begin
            bus2.memwrite = 1'b1; bus2.adr = 16'hC010; bus2.writedata = words[k];
            tick();
            bus2.memwrite = 1'b0; bus2.adr = '0; bus2.writedata = '0;
            busy_n = 0; done_at = 0; lat_n = 0; nb = 0; pat = '0; prev = 1'b0;
            for (int i = 1; i <= 20 && b_busy === 1'b1; i++) begin
                busy_n++;
                if (b_sr_clk && !prev) begin pat = {pat[0], b_sr_data}; nb++; end
                if (b_sr_latch) lat_n++;
                if (b_done) done_at = i;
                prev = b_sr_clk;
                tick();
            end
            n_chk++; if (busy_n != 5 || done_at != 5 || lat_n != 1) begin n_fail++; $display("FAIL bound_timing: word %h got busy %0d done@%0d latch %0d expected 5 5 1", words[k], busy_n, done_at, lat_n); end
            n_chk++; if (nb != 2 || pat !== words[k][1:0]) begin n_fail++; $display("FAIL bound_pattern: word %h got %0d bits %b expected 2 bits %b", words[k], nb, pat, words[k][1:0]); end
            tick();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_idle();
        rst = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        test_addr_filter();
        test_random();
        test_boundary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
